lea_byte_scheduler: RTL and testbench
=====================================

LEA_BYTE_SCHEDULER -- requirements
Module: lea_byte_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: LSB_FIRST, 1, byte 0 = in_data[7:0] when 1, byte 0 = in_data[127:120] when 0.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream 128-bit block offered.
REQ-006 in_ready  output  1  block can be accepted this cycle.
REQ-007 in_data  input  128  LEA state block; sampled only on in_valid && in_ready.
REQ-008 out_valid  output  1  out_byte is valid.
REQ-009 out_ready  input  1  downstream accepts current byte.
REQ-010 out_byte  output  8  current byte of the held block.
REQ-011 out_idx  output  4  index (0..15) of out_byte in the 16x8 split.
REQ-012 out_last  output  1  high with out_valid when out_idx = 15.
REQ-013 busy  output  1  high while a block is held (state SEND).

Function
REQ-014 The FSM SHALL have two states: IDLE (no block held) and SEND (block held, bytes pending).
REQ-015 In IDLE: in_ready = 1, out_valid = 0; on in_valid, the block is captured into a 128-bit holding register, idx <= 0, next state SEND.
REQ-016 In SEND: out_valid = 1; out_byte = byte[idx] of the held block per LSB_FIRST; out_idx = idx.
REQ-017 A byte transfer occurs on out_valid && out_ready; idx increments by 1 on each transfer, with no change otherwise.
REQ-018 out_byte, out_idx and out_last SHALL stay stable while out_valid && !out_ready.
REQ-019 In SEND, in_ready = out_last && out_ready (combinational), so a new block is accepted in the same cycle the last byte transfers.
REQ-020 Last-byte transfer with in_valid high: capture the new block, idx <= 0, remain in SEND, with no bubble cycle.
REQ-021 Last-byte transfer with in_valid low: idx wraps to 0, next state IDLE.
REQ-022 First-byte latency: out_valid rises the cycle after block acceptance; sustained throughput is 1 byte/cycle and 16 cycles/block with out_ready held high.
REQ-023 in_data SHALL be ignored whenever in_ready = 0; the held block SHALL never change mid-block.
REQ-024 idx is a 4-bit counter; no out-of-range index SHALL exist.

Reset
REQ-025 On rst = 1 at a clock edge: state <= IDLE, idx <= 0, holding register <= 0.
REQ-026 Outputs during and after reset until first accept: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_byte = 0, out_idx = 0.
REQ-027 Reset mid-block SHALL discard the held block and remaining bytes; no further bytes of that block are emitted.
REQ-028 rst SHALL take priority over simultaneous in_valid/out_ready.

Structure
REQ-029 A shared package lea_pkg SHALL hold LEA_BLOCK_W = 128, LEA_BYTE_W = 8, LEA_NBYTES = 16, and the state enum typedef.
REQ-030 Byte selection SHALL be one sub-module, lea_byte_mux (128-bit block + 4-bit index -> 8-bit byte, LSB_FIRST parameter), with purely combinational content.
REQ-031 All other logic (FSM, counter, holding register) SHALL be in lea_byte_scheduler.

Verification
REQ-032 Reset and idle check: rst for 2 cycles -> in_ready = 1, out_valid = 0, busy = 0, out_idx = 0.
REQ-033 Single block, LSB_FIRST = 1, in_data = 0x0F0E0D0C0B0A09080706050403020100, out_ready always 1 -> bytes 0x00..0x0F on 16 consecutive cycles, out_last only on 0x0F, then IDLE.
REQ-034 Backpressure: the same block with out_ready low on idx 3 for 5 cycles -> out_byte = 0x03 and out_idx = 3 held stable, no byte lost or duplicated.
REQ-035 Back-to-back: blocks A = 0x00..0F and B = 0x3F7759283F3... held valid -> in_ready pulses only on A's last byte, and B byte 0 appears the next cycle (32 bytes in 32 cycles).
REQ-036 Reset mid-block: rst asserted after idx = 7 -> next cycle out_valid = 0, in_ready = 1; a new block then restarts at idx 0.
REQ-037 LSB_FIRST = 0 with the REQ-033 block -> first byte 0x0F, last byte 0x00.

Source files
------------

// File: rtl/lea_pkg.sv
// rtl/lea_pkg.sv - shared widths and FSM state type for the LEA byte scheduler
package lea_pkg;
    localparam int LEA_BLOCK_W = 128;
    localparam int LEA_BYTE_W  = 8;
    localparam int LEA_NBYTES  = 16;
    localparam int LEA_IDX_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } lea_state_e;
endpackage

// File: rtl/lea_byte_scheduler_if.sv
// rtl/lea_byte_scheduler_if.sv - block-in / byte-out handshake bundle
interface lea_byte_scheduler_if;
    import lea_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [LEA_BLOCK_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LEA_BYTE_W-1:0]  out_byte;
    logic [LEA_IDX_W-1:0]   out_idx;
    logic                   out_last;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_byte, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_byte, out_idx, out_last, busy
    );
endinterface

// File: rtl/lea_byte_mux.sv
// rtl/lea_byte_mux.sv - selects one byte of a 128-bit block by index
module lea_byte_mux
    import lea_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [LEA_BLOCK_W-1:0] blk,
    input  logic [LEA_IDX_W-1:0]   idx,
    output logic [LEA_BYTE_W-1:0]  byte_o
);
    logic [LEA_IDX_W-1:0] sel;

    // MSB-first order is the same split walked backwards: byte k sits at slot 15-k.
    assign sel    = LSB_FIRST ? idx : ~idx;
    assign byte_o = blk[{sel, 3'b000} +: LEA_BYTE_W];
endmodule

// File: rtl/lea_byte_scheduler.sv
// rtl/lea_byte_scheduler.sv - holds one LEA block and streams it out a byte per handshake
module lea_byte_scheduler
    import lea_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    lea_byte_scheduler_if.slave  bus
);
    lea_state_e             state_q, state_d;
    logic [LEA_IDX_W-1:0]   idx_q, idx_d;
    logic [LEA_BLOCK_W-1:0] hold_q, hold_d;

    logic                   in_ready_c;
    logic                   out_valid_c;
    logic                   out_last_c;
    logic [LEA_BYTE_W-1:0]  mux_byte;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid_c = 1'b1;
                out_last_c  = (idx_q == LEA_IDX_W'(LEA_NBYTES - 1));
                // Accepting on the last transfer lets the next block follow with no bubble.
                in_ready_c  = out_last_c && bus.out_ready;
                if (bus.out_ready) begin
                    if (out_last_c) begin
                        idx_d = '0;
                        if (bus.in_valid) begin
                            hold_d = bus.in_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + LEA_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    lea_byte_mux #(
        .LSB_FIRST (LSB_FIRST)
    ) u_mux (
        .blk    (hold_q),
        .idx    (idx_q),
        .byte_o (mux_byte)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_byte  = mux_byte;
    assign bus.out_idx   = idx_q;
    assign bus.busy      = (state_q == ST_SEND);
endmodule

// File: tb/tb_lea_byte_scheduler.sv
// tb/tb_lea_byte_scheduler.sv - self-checking bench for lea_byte_scheduler (both byte orders)
module tb_lea_byte_scheduler;
    logic clk;
    logic rst;

    lea_byte_scheduler_if ifa ();
    lea_byte_scheduler_if ifb ();

    lea_byte_scheduler #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    lea_byte_scheduler #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];

    logic         cur_rst;
    logic         cur_iv;
    logic [127:0] cur_d;
    logic         cur_ordy;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       exp_ov;
        logic [7:0] exp_b1;
        logic [7:0] exp_b0;
        logic [3:0] exp_idx;
        logic       exp_last;
        logic       exp_ir;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [127:0] d, input logic ordy);
        cur_rst = r; cur_iv = iv; cur_d = d; cur_ordy = ordy;
        rst = r;
        ifa.in_valid = iv; ifb.in_valid = iv;
        ifa.in_data = d;   ifb.in_data = d;
        ifa.out_ready = ordy; ifb.out_ready = ordy;
        #2;
    endtask

    task automatic model_check();
        logic exp_ir;
        int   n;
        n = q1.size();
        exp_ir = (n == 0) || (n == 1 && cur_ordy);
        chk("lsb_out_valid", ifa.out_valid, n != 0);
        chk("msb_out_valid", ifb.out_valid, n != 0);
        chk("lsb_busy", ifa.busy, n != 0);
        chk("msb_busy", ifb.busy, n != 0);
        chk("lsb_out_last", ifa.out_last, n == 1);
        chk("msb_out_last", ifb.out_last, n == 1);
        chk("lsb_in_ready", ifa.in_ready, exp_ir);
        chk("msb_in_ready", ifb.in_ready, exp_ir);
        if (n != 0) begin
            chk("lsb_out_byte", ifa.out_byte, q1[0]);
            chk("msb_out_byte", ifb.out_byte, q0[0]);
            chk("lsb_out_idx", ifa.out_idx, 16 - n);
            chk("msb_out_idx", ifb.out_idx, 16 - n);
        end
    endtask

    // Reference: a block acceptance enqueues 16 bytes, each transfer dequeues one.
    task automatic advance();
        logic acc;
        if (cur_rst) begin
            q1.delete();
            q0.delete();
        end else begin
            acc = cur_iv && ((q1.size() == 0) || (q1.size() == 1 && cur_ordy));
            if (q1.size() != 0 && cur_ordy) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < 16; k++) begin
                    q1.push_back(8'((cur_d >> (8 * k)) & 128'hFF));
                    q0.push_back(8'((cur_d >> (8 * (15 - k))) & 128'hFF));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] blk_c;
    logic [127:0] blk_d;

    initial begin
        int   stall;
        int   irp;
        int   xf;
        logic ordy;
        logic iv;

        blk_a = 128'h0F0E0D0C0B0A09080706050403020100;
        blk_b = 128'h3F7759283F3A1B2C4D5E6F708192A3B4;
        blk_c = 128'hA5A4A3A2A1A0AFAEADACABAAA9A8A7A6;
        blk_d = 128'h112233445566778899AABBCCDDEEFF00;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b1, 8'(i - 1), 8'(16 - i), 4'(i - 1), (i == 16), (i == 16)};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1};

        // Reset for two cycles, then idle state
        cur_rst = 1'b1; cur_iv = 1'b0; cur_d = '0; cur_ordy = 1'b0;
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        ifa.in_data = '0; ifb.in_data = '0;
        ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, '0, 1'b0);
        advance();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("rst_in_ready", ifa.in_ready, 1'b1);
        chk("rst_out_valid", ifa.out_valid, 1'b0);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_out_idx", ifa.out_idx, 4'd0);
        chk("rst_out_byte", ifa.out_byte, 8'h00);
        chk("rst_out_last", ifa.out_last, 1'b0);
        chk("rst_msb_out_byte", ifb.out_byte, 8'h00);
        model_check();
        advance();

        // Single block, full throughput
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, tbl[i].iv, blk_a, tbl[i].ordy);
            chk("tbl_out_valid", ifa.out_valid, tbl[i].exp_ov);
            chk("tbl_in_ready", ifa.in_ready, tbl[i].exp_ir);
            chk("tbl_out_last", ifa.out_last, tbl[i].exp_last);
            if (tbl[i].exp_ov) begin
                chk("tbl_lsb_byte", ifa.out_byte, tbl[i].exp_b1);
                chk("tbl_msb_byte", ifb.out_byte, tbl[i].exp_b0);
                chk("tbl_out_idx", ifa.out_idx, tbl[i].exp_idx);
            end
            model_check();
            advance();
        end

        // Backpressure on idx 3 for 5 cycles
        drive(1'b0, 1'b1, blk_a, 1'b1);
        model_check();
        advance();
        stall = 0;
        for (int c = 0; c < 21; c++) begin
            ordy = !(q1.size() == 13 && stall < 5);
            if (!ordy) stall++;
            drive(1'b0, 1'b0, blk_a, ordy);
            model_check();
            if (!ordy) begin
                chk("bp_lsb_byte", ifa.out_byte, 8'h03);
                chk("bp_lsb_idx", ifa.out_idx, 4'd3);
                chk("bp_msb_byte", ifb.out_byte, 8'h0C);
            end
            advance();
        end
        drive(1'b0, 1'b0, blk_a, 1'b1);
        chk("bp_done_idle", ifa.out_valid, 1'b0);
        model_check();
        advance();

        // Back-to-back blocks, 32 bytes in 32 cycles
        drive(1'b0, 1'b1, blk_a, 1'b1);
        model_check();
        advance();
        irp = 0;
        xf = 0;
        for (int c = 1; c <= 32; c++) begin
            iv = (c <= 16);
            drive(1'b0, iv, blk_b, 1'b1);
            model_check();
            if (c <= 16 && ifa.in_ready) irp++;
            if (c == 16) chk("b2b_ready_on_last", ifa.in_ready, 1'b1);
            if (c == 17) begin
                chk("b2b_first_b_lsb", ifa.out_byte, blk_b[7:0]);
                chk("b2b_first_b_msb", ifb.out_byte, blk_b[127:120]);
                chk("b2b_first_b_idx", ifa.out_idx, 4'd0);
            end
            if (ifa.out_valid && ifa.out_ready) xf++;
            advance();
        end
        chk("b2b_ready_pulses", irp, 1);
        chk("b2b_bytes", xf, 32);

        // Reset after idx 7 is transferred
        drive(1'b0, 1'b1, blk_c, 1'b1);
        model_check();
        advance();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, blk_c, 1'b1);
            model_check();
            advance();
        end
        drive(1'b1, 1'b1, blk_d, 1'b1);
        model_check();
        advance();
        drive(1'b0, 1'b0, blk_d, 1'b1);
        chk("mid_rst_out_valid", ifa.out_valid, 1'b0);
        chk("mid_rst_in_ready", ifa.in_ready, 1'b1);
        model_check();
        advance();
        drive(1'b0, 1'b1, blk_d, 1'b0);
        model_check();
        advance();
        drive(1'b0, 1'b0, blk_d, 1'b0);
        chk("restart_valid", ifa.out_valid, 1'b1);
        chk("restart_idx", ifa.out_idx, 4'd0);
        chk("restart_byte", ifa.out_byte, blk_d[7:0]);
        model_check();
        advance();

        // Randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 6,
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 3) != 0);
            model_check();
            advance();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
